mask_rand_gen: RTL and testbench

Fresh-randomness source for the DOM-masked substitution layer of the 64-bit masked cipher datapath. Holds three independent 96-bit Fibonacci LFSRs that are seeded over a 32-bit word stream, and presents them as the `az`, `bz` and `z` buses consumed by the 16-S-box substitution stage. Each bus carries 6 bits per S-box. The block sits directly upstream of the substitution stage and advances on a valid/ready handshake, so no randomness word is ever reused.

---
 rtl/mask_rand_gen.sv | 146 ++++++++++++++
 tb/tb_mask_rand_gen.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mask_rand_gen.sv
// mask_rand_gen: fresh-randomness source for the DOM-masked S-box layer.
// Three 96-bit Fibonacci LFSRs (LA/LB/LZ) are seeded over a 32-bit word
// stream, warmed up, and then advanced once per consumer handshake.
//
// state | meaning
// ------+---------------------------------------------------------------
// EMPTY | no seed yet; waiting for the first seed word
// LOAD  | seed words being shifted in (cnt counts accepted words)
// WARM  | zero-fixed seed present; two advances before output is valid
// RUN   | az/bz/z valid; advance on rnd_valid && rnd_ready

module mask_rand_gen #(
  parameter int STEP = 96
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seed_valid,
  input  logic [31:0] seed_data,
  output logic        seed_ready,
  output logic        rnd_valid,
  input  logic        rnd_ready,
  output logic [95:0] az,
  output logic [95:0] bz,
  output logic [95:0] z
);

  typedef enum logic [1:0] {EMPTY, LOAD, WARM, RUN} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [1:0]  warm_cnt, warm_nxt;
  logic [95:0] la, lb, lz;
  logic [95:0] la_nxt, lb_nxt, lz_nxt;
  logic [95:0] la_sh, lb_sh, lz_sh;
  logic        seed_fire;

  // STEP single steps of the Fibonacci LFSR, unrolled within one clock.
  function automatic logic [95:0] lfsr_adv(input logic [95:0] s);
    logic [95:0] r;
    r = s;
    for (int i = 0; i < STEP; i++) begin
      r = {r[94:0], r[95] ^ r[93] ^ r[48] ^ r[46]};
    end
    return r;
  endfunction

  // An all-zero LFSR would lock up forever, so it is forced to 1.
  function automatic logic [95:0] nz_fix(input logic [95:0] s);
    return (s == 96'h0) ? 96'h1 : s;
  endfunction

  assign seed_ready = (state != WARM);
  assign rnd_valid  = (state == RUN);
  assign seed_fire  = seed_valid && seed_ready;

  assign la_sh = {la[63:0], lb[95:64]};
  assign lb_sh = {lb[63:0], lz[95:64]};
  assign lz_sh = {lz[63:0], seed_data};

  assign az = la;
  assign bz = lb;
  assign z  = lz;

  // Next-state, counters and LFSR updates; seed acceptance beats advance.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    warm_nxt  = warm_cnt;
    la_nxt    = la;
    lb_nxt    = lb;
    lz_nxt    = lz;
    case (state)
      EMPTY: begin
        if (seed_fire) begin
          la_nxt    = la_sh;
          lb_nxt    = lb_sh;
          lz_nxt    = lz_sh;
          cnt_nxt   = 4'd1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (seed_fire) begin
          if (cnt == 4'd8) begin
            la_nxt    = nz_fix(la_sh);
            lb_nxt    = nz_fix(lb_sh);
            lz_nxt    = nz_fix(lz_sh);
            cnt_nxt   = 4'd0;
            warm_nxt  = 2'd0;
            state_nxt = WARM;
          end else begin
            la_nxt  = la_sh;
            lb_nxt  = lb_sh;
            lz_nxt  = lz_sh;
            cnt_nxt = cnt + 4'd1;
          end
        end
      end
      WARM: begin
        la_nxt = lfsr_adv(la);
        lb_nxt = lfsr_adv(lb);
        lz_nxt = lfsr_adv(lz);
        if (warm_cnt == 2'd1) begin
          warm_nxt  = 2'd0;
          state_nxt = RUN;
        end else begin
          warm_nxt = warm_cnt + 2'd1;
        end
      end
      RUN: begin
        if (seed_fire) begin
          la_nxt    = la_sh;
          lb_nxt    = lb_sh;
          lz_nxt    = lz_sh;
          cnt_nxt   = 4'd1;
          state_nxt = LOAD;
        end else if (rnd_ready) begin
          la_nxt = lfsr_adv(la);
          lb_nxt = lfsr_adv(lb);
          lz_nxt = lfsr_adv(lz);
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // State, counter and LFSR registers; reset discards any partial seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      cnt      <= 4'd0;
      warm_cnt <= 2'd0;
      la       <= 96'h0;
      lb       <= 96'h0;
      lz       <= 96'h0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      warm_cnt <= warm_nxt;
      la       <= la_nxt;
      lb       <= lb_nxt;
      lz       <= lz_nxt;
    end
  end

endmodule

// File: tb/tb_mask_rand_gen.sv
// tb_mask_rand_gen: directed bench for mask_rand_gen. Two instances share
// all inputs: one with STEP=1 (hand-computable values) and one with the
// default STEP=96 (checked against a software LFSR model).

module tb_mask_rand_gen;

  logic        clk;
  logic        rst_n;
  logic        seed_valid;
  logic [31:0] seed_data;
  logic        rnd_ready;

  logic        seed_ready_s1, rnd_valid_s1;
  logic [95:0] az_s1, bz_s1, z_s1;
  logic        seed_ready_s96, rnd_valid_s96;
  logic [95:0] az_s96, bz_s96, z_s96;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] words [9];
  logic [95:0] e1_a, e1_b, e1_z, e96_a, e96_b, e96_z;
  logic [95:0] t_a, t_z;

  mask_rand_gen #(.STEP(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .seed_valid(seed_valid), .seed_data(seed_data),
    .seed_ready(seed_ready_s1), .rnd_valid(rnd_valid_s1), .rnd_ready(rnd_ready),
    .az(az_s1), .bz(bz_s1), .z(z_s1)
  );

  mask_rand_gen dut_s96 (
    .clk(clk), .rst_n(rst_n), .seed_valid(seed_valid), .seed_data(seed_data),
    .seed_ready(seed_ready_s96), .rnd_valid(rnd_valid_s96), .rnd_ready(rnd_ready),
    .az(az_s96), .bz(bz_s96), .z(z_s96)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [95:0] model_adv(input logic [95:0] s, input int n);
    logic [95:0] r;
    r = s;
    for (int i = 0; i < n; i++) r = {r[94:0], r[95] ^ r[93] ^ r[48] ^ r[46]};
    return r;
  endfunction

  function automatic logic [95:0] model_fix(input logic [95:0] s);
    return (s == 96'h0) ? 96'h1 : s;
  endfunction

  // Expected RUN-entry values for the nine words in 'words'.
  task automatic compute_exp();
    logic [95:0] a0, b0, z0;
    a0 = model_fix({words[0], words[1], words[2]});
    b0 = model_fix({words[3], words[4], words[5]});
    z0 = model_fix({words[6], words[7], words[8]});
    e1_a  = model_adv(a0, 2);
    e1_b  = model_adv(b0, 2);
    e1_z  = model_adv(z0, 2);
    e96_a = model_adv(a0, 192);
    e96_b = model_adv(b0, 192);
    e96_z = model_adv(z0, 192);
  endtask

  // Drive one seed word; returns 1 time unit after the accepting edge.
  task automatic send_word(input logic [31:0] w);
    seed_valid = 1'b1;
    seed_data  = w;
    @(posedge clk);
    #1;
    seed_valid = 1'b0;
    seed_data  = 32'h0;
  endtask

  task automatic load_words();
    for (int i = 0; i < 9; i++) send_word(words[i]);
  endtask

  task automatic check_run_entry(input string tag);
    check_val({tag, "_valid_e0"}, {95'h0, rnd_valid_s1}, 96'h0);
    @(posedge clk); #1;
    check_val({tag, "_valid_e1"}, {95'h0, rnd_valid_s1}, 96'h0);
    check_val({tag, "_sready_warm"}, {95'h0, seed_ready_s1}, 96'h0);
    @(posedge clk); #1;
    check_val({tag, "_valid_s1"}, {95'h0, rnd_valid_s1}, 96'h1);
    check_val({tag, "_valid_s96"}, {95'h0, rnd_valid_s96}, 96'h1);
    check_val({tag, "_az_s1"}, az_s1, e1_a);
    check_val({tag, "_bz_s1"}, bz_s1, e1_b);
    check_val({tag, "_z_s1"}, z_s1, e1_z);
    check_val({tag, "_az_s96"}, az_s96, e96_a);
    check_val({tag, "_bz_s96"}, bz_s96, e96_b);
    check_val({tag, "_z_s96"}, z_s96, e96_z);
  endtask

  initial begin
    rst_n      = 1'b0;
    seed_valid = 1'b0;
    seed_data  = 32'h0;
    rnd_ready  = 1'b0;
    #3;
    check_val("rst_az", az_s1, 96'h0);
    check_val("rst_valid", {95'h0, rnd_valid_s1}, 96'h0);
    check_val("rst_sready", {95'h0, seed_ready_s1}, 96'h1);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // Seed 0,0,1,0,0,2,0,0,3 -> 4/8/C after two single-step advances.
    words = '{32'h0, 32'h0, 32'h1, 32'h0, 32'h0, 32'h2, 32'h0, 32'h0, 32'h3};
    compute_exp();
    load_words();
    check_run_entry("seed");
    check_val("seed_hand_az", az_s1, 96'h4);
    check_val("seed_hand_bz", bz_s1, 96'h8);
    check_val("seed_hand_z", z_s1, 96'hC);

    // Backpressure: five held cycles, then one handshake.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_val("hold_az_s96", az_s96, e96_a);
      check_val("hold_z_s96", z_s96, e96_z);
    end
    rnd_ready = 1'b1;
    @(posedge clk); #1;
    rnd_ready = 1'b0;
    check_val("adv_az_s96", az_s96, model_adv(e96_a, 96));
    check_val("adv_bz_s96", bz_s96, model_adv(e96_b, 96));
    check_val("adv_z_s96", z_s96, model_adv(e96_z, 96));
    check_val("adv_az_s1", az_s1, 96'h8);
    check_val("adv_z_s1", z_s1, 96'h18);
    @(posedge clk); #1;
    check_val("post_adv_hold", az_s96, model_adv(e96_a, 96));

    // Asynchronous reset mid-cycle.
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_az", az_s96, 96'h0);
    check_val("arst_bz", bz_s96, 96'h0);
    check_val("arst_z", z_s1, 96'h0);
    check_val("arst_valid", {95'h0, rnd_valid_s96}, 96'h0);
    check_val("arst_sready", {95'h0, seed_ready_s96}, 96'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // All-zero seed: zero-fix then two advances.
    words = '{default: 32'h0};
    compute_exp();
    load_words();
    check_run_entry("zero");
    check_val("zero_hand_az", az_s1, 96'h4);
    check_val("zero_hand_z", z_s1, 96'h4);

    // Reseed during RUN with simultaneous rnd_ready: no advance.
    t_a = {e96_a[63:0], e96_b[95:64]};
    t_z = {e96_z[63:0], 32'h0000_00A5};
    rnd_ready = 1'b1;
    send_word(32'h0000_00A5);
    rnd_ready = 1'b0;
    check_val("reseed_valid", {95'h0, rnd_valid_s1}, 96'h0);
    check_val("reseed_az_s1", az_s1, 96'h4_0000_0000);
    check_val("reseed_z_s1", z_s1, 96'h4_0000_00A5);
    check_val("reseed_az_s96", az_s96, t_a);
    check_val("reseed_z_s96", z_s96, t_z);
    words = '{32'h0000_00A5, 32'h8123_4567, 32'h89AB_CDEF, 32'hDEAD_BEEF,
              32'h0F0F_F0F0, 32'h1357_9BDF, 32'hFFFF_0001, 32'h4000_0000,
              32'hC0DE_CAFE};
    compute_exp();
    for (int i = 1; i < 9; i++) begin
      repeat (2) @(posedge clk);
      #1;
      check_val("reseed_load_valid", {95'h0, rnd_valid_s96}, 96'h0);
      send_word(words[i]);
    end
    check_run_entry("reseed");

    // Reset after four partial words, then a clean load.
    for (int i = 0; i < 4; i++) send_word(32'hA5A5_0000 + 32'(i));
    @(negedge clk);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    words = '{32'h0, 32'h0, 32'h1, 32'h0, 32'h0, 32'h2, 32'h0, 32'h0, 32'h3};
    compute_exp();
    load_words();
    check_run_entry("rstload");
    check_val("rstload_hand_bz", bz_s1, 96'h8);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
